ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
- Parametrised multi-cycle control unit for the rysy core; the next generation of the core controller.
- Decodes opcode/func3/func7/b into datapath selects: imm_mux, alu1_mux, alu2_mux, rd_mux, mem_addr_sel pc_sel, cmp, reg_file write, data-memory we.
- Replaces the fixed two-phase load with an explicit FSM:
  - req/ack memory handshake with timeout;
  - configurable flush depth after control transfers;
  - stall output for the fetch path.

Parameters:
- TIMEOUT, 15, max cycles in MEM waiting for mem_ack; 0 = wait forever.
- FLUSH_CYCLES, 1, NOP cycles inserted after a taken control transfer or memory op; legal 1..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- opcode  in  5  instruction bits [6:2].
- func3  in  3  instruction func3.
- func7  in  7  instruction func7.
- b  in  1  branch-condition result from cmp.
- mem_ack  in  1  data memory done; one-cycle pulse.
- md_done  in  1  mul/div unit done; ignored unless CTRL_MULDIV_EN.
- imm_type  out  3  imm_mux select.
- alu1_sel  out  1  ALU1_PC for BRANCH/JAL, else ALU1_RS.
- alu2_sel  out  1  ALU2_RS for OP, else ALU2_IMM.
- alu_op  out  4  ALU operation from func3/func7.
- cmp_op  out  3  cmp select from func3; default EQ.
- rd_sel  out  2  rd_mux select.
- pc_sel  out  2  mem_addr_sel select.
- reg_wr  out  1  register file write enable.
- we  out  1  data memory write enable.
- mem_req  out  1  data memory request.
- md_start  out  1  mul/div start pulse.
- stall  out  1  fetch must hold current instruction.
- next_nop  out  1  current fetched word is to be discarded.
- err  out  1  sticky memory timeout flag.
- illegal  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- States: RST_NOP, EXEC, MEM, WB, MD, FLUSH.
- Reset (rst==0 at posedge) wins over all other inputs:
  - state <= RST_NOP; counters cleared; err <= 0.
  - Outputs: reg_wr=0, we=0, mem_req=0, md_start=0, stall=0, illegal=0, next_nop=1, pc_sel=PC_OLD.
  - Reset mid-MEM abandons the access with no write.
- RST_NOP: one cycle with next_nop=1, pc_sel=PC_P4, then EXEC. The first instruction is never processed twice.
- EXEC, single-cycle ops (OP_IMM, LUI, OP, JAL, JALR, BRANCH):
  - Selects decoded combinationally.
  - reg_wr=1 for OP_IMM/LUI/OP/JAL/JALR.
  - rd_sel: RD_ALU for OP/OP_IMM, RD_IMM for LUI, RD_PCP4 for JAL/JALR.
  - pc_sel: PC_ALU for JAL/JALR and for BRANCH with b=1, else PC_P4.
  - JAL/JALR/taken BRANCH: go to FLUSH. Otherwise stay in EXEC.
- EXEC, LOAD/STORE:
  - mem_req=1, stall=1, pc_sel=PC_OLD; we=1 for STORE only.
  - Go to MEM; wait counter loads 1.
- MEM:
  - mem_req, we, stall, pc_sel=PC_OLD held.
  - Counter increments each cycle without ack.
  - mem_ack=1, LOAD: go to WB.
  - mem_ack=1, STORE: pc_sel=PC_P4 that cycle; go to FLUSH.
  - Counter==TIMEOUT (TIMEOUT!=0) with no ack: err <= 1, pc_sel=PC_P4, no reg write; go to FLUSH.
  - Ack in the same cycle as the timeout: ack wins.
- WB: one cycle with reg_wr=1, rd_sel=RD_MEM, pc_sel=PC_P4, stall=0; go to FLUSH.
- FLUSH:
  - next_nop=1, reg_wr=0, we=0, pc_sel=PC_P4 on the first cycle only, PC_OLD after.
  - Lasts FLUSH_CYCLES cycles; counter width 2; then EXEC.
- Unknown opcode in EXEC: treated as NOP (pc_sel=PC_P4, no writes), illegal=1 for one cycle; stay in EXEC.
- mem_ack outside MEM and md_done outside MD are ignored.
- next_nop and err are registered; all select outputs are combinational from state plus inputs.

Optional Feature:
- Macro CTRL_MULDIV_EN.
- Defined:
  - OP with func7=7'b0000001 in EXEC pulses md_start=1 for one cycle, stall=1, pc_sel=PC_OLD; go to MD.
  - MD holds stall until md_done.
  - On md_done: reg_wr=1, rd_sel=RD_ALU, pc_sel=PC_P4; return to EXEC (no flush).
- Undefined: MD state, md_start logic and the md_done path are not compiled. md_start is tied to 0, and OP with func7=0000001 raises illegal.

Decomposition:
- Shared package header ctrl_fsm_pkg.vh holds:
  - state encodings (3 bits);
  - TIMEOUT/FLUSH_CYCLES legality checks;
  - ALU op codes.
- Opcode, IMM_, ALU1_, ALU2_, RD_, PC_ and cmp encodings come from the team's existing shared headers.
- Sub-module ctrl_decode: purely combinational opcode/func decode producing imm_type, alu1_sel, alu2_sel, alu_op, cmp_op, rd_sel, default reg_wr and illegal. ctrl_fsm overrides these per state.

Test Plan:
- Reset: rst=0 for 2 cycles then 1, opcode=OP_IMM → reg_wr=0, next_nop=1 in the first cycle after release; reg_wr=1, pc_sel=PC_P4 in the second.
- Taken branch, FLUSH_CYCLES=2: opcode=BRANCH, b=1 → pc_sel=PC_ALU; then next_nop=1 for exactly 2 cycles; then EXEC. With b=0 → PC_P4, no flush.
- Load, ack on 3rd MEM cycle: mem_req high 4 cycles, stall high, pc_sel=PC_OLD; WB cycle with reg_wr=1, rd_sel=RD_MEM, pc_sel=PC_P4.
- Timeout, TIMEOUT=4: STORE, mem_ack never → we=1 for 4 MEM cycles; err=1 from cycle 5 and stays 1 until rst=0.
- Reset during MEM cycle 2 of a STORE → we=0, mem_req=0 the next cycle; state RST_NOP; no reg_wr.
- CTRL_MULDIV_EN, OP with func7=0000001, md_done after 5 cycles → md_start pulses once, stall 6 cycles, reg_wr=1 on the done cycle. Without the macro → illegal=1.

Source files
------------

// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the rysy core controller.
// Holds the controller state encoding, the opcode and datapath-select encodings,
// the ALU and comparator operation codes, and helpers for parameter legality.
package ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    StRstNop = 3'd0,
    StExec   = 3'd1,
    StMem    = 3'd2,
    StWb     = 3'd3,
    StMd     = 3'd4,
    StFlush  = 3'd5
  } state_e;

  // Instruction bits [6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic ALU1_RS = 1'b0;
  localparam logic ALU1_PC = 1'b1;

  localparam logic ALU2_IMM = 1'b0;
  localparam logic ALU2_RS  = 1'b1;

  localparam logic [1:0] RD_ALU  = 2'd0;
  localparam logic [1:0] RD_IMM  = 2'd1;
  localparam logic [1:0] RD_PCP4 = 2'd2;
  localparam logic [1:0] RD_MEM  = 2'd3;

  localparam logic [1:0] PC_OLD = 2'd0;
  localparam logic [1:0] PC_P4  = 2'd1;
  localparam logic [1:0] PC_ALU = 2'd2;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LT  = 3'd2;
  localparam logic [2:0] CMP_GE  = 3'd3;
  localparam logic [2:0] CMP_LTU = 3'd4;
  localparam logic [2:0] CMP_GEU = 3'd5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // alt selects SUB/SRA; callers decide when func7[5] is meaningful.
  function automatic logic [3:0] alu_op_from_f3(logic [2:0] f3, logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [2:0] cmp_op_from_f3(logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      3'b001:  op = CMP_NE;
      3'b100:  op = CMP_LT;
      3'b101:  op = CMP_GE;
      3'b110:  op = CMP_LTU;
      3'b111:  op = CMP_GEU;
      default: op = CMP_EQ;
    endcase
    return op;
  endfunction

  function automatic bit flush_cycles_ok(int unsigned n);
    return (n >= 1) && (n <= 3);
  endfunction

  function automatic bit timeout_ok(int unsigned t);
    return t <= 65535;
  endfunction

  // Wait counter must be able to hold TIMEOUT itself.
  function automatic int unsigned cnt_width(int unsigned t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/ctrl_fsm_decode.sv
// Purely combinational opcode/func decode for the rysy controller.
// Inputs : opcode_i (instr[6:2]), func3_i, func7_i.
// Outputs: datapath selects (imm_type_o, alu1_sel_o, alu2_sel_o, alu_op_o, cmp_op_o, rd_sel_o),
//          default reg_wr_o, illegal_o, and instruction-class flags for the FSM.
// Build option: CTRL_MULDIV_EN adds is_muldiv_o; without it OP/func7=0000001 is illegal.
module ctrl_decode
  import ctrl_fsm_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output logic [2:0] imm_type_o,
  output logic       alu1_sel_o,
  output logic       alu2_sel_o,
  output logic [3:0] alu_op_o,
  output logic [2:0] cmp_op_o,
  output logic [1:0] rd_sel_o,
  output logic       reg_wr_o,
  output logic       illegal_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_jump_o,
`ifdef CTRL_MULDIV_EN
  output logic       is_muldiv_o,
`endif
  output logic       is_branch_o
);

  always_comb begin
    imm_type_o  = IMM_I;
    alu1_sel_o  = ALU1_RS;
    alu2_sel_o  = ALU2_IMM;
    alu_op_o    = ALU_ADD;
    cmp_op_o    = CMP_EQ;
    rd_sel_o    = RD_ALU;
    reg_wr_o    = 1'b0;
    illegal_o   = 1'b0;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    is_jump_o   = 1'b0;
    is_branch_o = 1'b0;
`ifdef CTRL_MULDIV_EN
    is_muldiv_o = 1'b0;
`endif
    case (opcode_i)
      OPC_OP_IMM: begin
        // Only shifts-right use func7[5]; ADDI must never become SUB.
        alu_op_o = alu_op_from_f3(func3_i, (func3_i == 3'b101) && func7_i[5]);
        reg_wr_o = 1'b1;
      end
      OPC_OP: begin
        alu2_sel_o = ALU2_RS;
        alu_op_o   = alu_op_from_f3(func3_i, func7_i[5]);
        if (func7_i == F7_MULDIV) begin
`ifdef CTRL_MULDIV_EN
          is_muldiv_o = 1'b1;
`else
          illegal_o   = 1'b1;
`endif
        end else begin
          reg_wr_o = 1'b1;
        end
      end
      OPC_LUI: begin
        imm_type_o = IMM_U;
        rd_sel_o   = RD_IMM;
        reg_wr_o   = 1'b1;
      end
      OPC_JAL: begin
        imm_type_o = IMM_J;
        alu1_sel_o = ALU1_PC;
        rd_sel_o   = RD_PCP4;
        reg_wr_o   = 1'b1;
        is_jump_o  = 1'b1;
      end
      OPC_JALR: begin
        rd_sel_o  = RD_PCP4;
        reg_wr_o  = 1'b1;
        is_jump_o = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type_o  = IMM_B;
        alu1_sel_o  = ALU1_PC;
        cmp_op_o    = cmp_op_from_f3(func3_i);
        is_branch_o = 1'b1;
      end
      OPC_LOAD: begin
        is_load_o = 1'b1;
      end
      OPC_STORE: begin
        imm_type_o = IMM_S;
        is_store_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit for the rysy core.
// Decodes the instruction into datapath selects and sequences memory accesses (req/ack with
// timeout), post-transfer flush cycles and, optionally, mul/div operations.
// Inputs : clk, rst (synchronous, active-low), opcode, func3, func7, b, mem_ack, md_done.
// Outputs: imm_type, alu1_sel, alu2_sel, alu_op, cmp_op, rd_sel, pc_sel, reg_wr, we, mem_req,
//          md_start, stall, next_nop (registered), err (registered, sticky), illegal.
// Build option: define CTRL_MULDIV_EN to enable the MD state and the md_start/md_done path.
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       b,
  input  logic       mem_ack,
  input  logic       md_done,
  output logic [2:0] imm_type,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [3:0] alu_op,
  output logic [2:0] cmp_op,
  output logic [1:0] rd_sel,
  output logic [1:0] pc_sel,
  output logic       reg_wr,
  output logic       we,
  output logic       mem_req,
  output logic       md_start,
  output logic       stall,
  output logic       next_nop,
  output logic       err,
  output logic       illegal
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
  localparam logic [1:0] FlushLast = 2'(FLUSH_CYCLES - 1);

  if (!flush_cycles_ok(FLUSH_CYCLES)) begin : gen_bad_flush
    $error("ctrl_fsm: FLUSH_CYCLES must be in 1..3");
  end
  if (!timeout_ok(TIMEOUT)) begin : gen_bad_timeout
    $error("ctrl_fsm: TIMEOUT out of range");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]      flush_cnt_q, flush_cnt_d;
  logic            mem_we_q, mem_we_d;
  logic            err_q, err_d;
  logic            next_nop_q, next_nop_d;

  logic [1:0] dec_rd_sel;
  logic       dec_reg_wr, dec_illegal;
  logic       dec_is_load, dec_is_store, dec_is_jump, dec_is_branch;
`ifdef CTRL_MULDIV_EN
  logic       dec_is_muldiv;
`else
  logic       unused_md_done;
  assign unused_md_done = md_done;
`endif

  ctrl_decode u_decode (
    .opcode_i    (opcode),
    .func3_i     (func3),
    .func7_i     (func7),
    .imm_type_o  (imm_type),
    .alu1_sel_o  (alu1_sel),
    .alu2_sel_o  (alu2_sel),
    .alu_op_o    (alu_op),
    .cmp_op_o    (cmp_op),
    .rd_sel_o    (dec_rd_sel),
    .reg_wr_o    (dec_reg_wr),
    .illegal_o   (dec_illegal),
    .is_load_o   (dec_is_load),
    .is_store_o  (dec_is_store),
    .is_jump_o   (dec_is_jump),
`ifdef CTRL_MULDIV_EN
    .is_muldiv_o (dec_is_muldiv),
`endif
    .is_branch_o (dec_is_branch)
  );

  logic timed_out;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt_q == TimeoutCnt);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mem_we_d    = mem_we_q;
    err_d       = err_q;
    rd_sel      = dec_rd_sel;
    pc_sel      = PC_OLD;
    reg_wr      = 1'b0;
    we          = 1'b0;
    mem_req     = 1'b0;
    md_start    = 1'b0;
    stall       = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      StRstNop: begin
        pc_sel  = PC_P4;
        state_d = StExec;
      end
      StExec: begin
        if (dec_illegal) begin
          pc_sel  = PC_P4;
          illegal = 1'b1;
        end else if (dec_is_load || dec_is_store) begin
          mem_req    = 1'b1;
          we         = dec_is_store;
          stall      = 1'b1;
          mem_we_d   = dec_is_store;
          wait_cnt_d = CntW'(1);
          state_d    = StMem;
`ifdef CTRL_MULDIV_EN
        end else if (dec_is_muldiv) begin
          md_start = 1'b1;
          stall    = 1'b1;
          state_d  = StMd;
`endif
        end else begin
          reg_wr = dec_reg_wr;
          if (dec_is_jump || (dec_is_branch && b)) begin
            pc_sel      = PC_ALU;
            flush_cnt_d = 2'd0;
            state_d     = StFlush;
          end else begin
            pc_sel = PC_P4;
          end
        end
      end
      StMem: begin
        mem_req = 1'b1;
        we      = mem_we_q;
        stall   = 1'b1;
        // Ack has priority over a timeout landing on the same cycle.
        if (mem_ack) begin
          if (mem_we_q) begin
            pc_sel      = PC_P4;
            stall       = 1'b0;
            flush_cnt_d = 2'd0;
            state_d     = StFlush;
          end else begin
            state_d = StWb;
          end
        end else if (timed_out) begin
          err_d       = 1'b1;
          pc_sel      = PC_P4;
          stall       = 1'b0;
          flush_cnt_d = 2'd0;
          state_d     = StFlush;
        end else if (TIMEOUT != 0) begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StWb: begin
        reg_wr      = 1'b1;
        rd_sel      = RD_MEM;
        pc_sel      = PC_P4;
        flush_cnt_d = 2'd0;
        state_d     = StFlush;
      end
`ifdef CTRL_MULDIV_EN
      StMd: begin
        stall = 1'b1;
        if (md_done) begin
          reg_wr  = 1'b1;
          rd_sel  = RD_ALU;
          pc_sel  = PC_P4;
          stall   = 1'b0;
          state_d = StExec;
        end
      end
`endif
      StFlush: begin
        // Advance past the discarded word once, then hold.
        pc_sel = (flush_cnt_q == 2'd0) ? PC_P4 : PC_OLD;
        if (flush_cnt_q >= FlushLast) begin
          state_d = StExec;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = StRstNop;
      end
    endcase

    // Reset overrides every output for the cycle it is asserted.
    if (!rst) begin
      pc_sel   = PC_OLD;
      reg_wr   = 1'b0;
      we       = 1'b0;
      mem_req  = 1'b0;
      md_start = 1'b0;
      stall    = 1'b0;
      illegal  = 1'b0;
    end

    next_nop_d = (state_d == StRstNop) || (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StRstNop;
      wait_cnt_q  <= '0;
      flush_cnt_q <= 2'd0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      next_nop_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
      next_nop_q  <= next_nop_d;
    end
  end

  assign next_nop = next_nop_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;
  import ctrl_fsm_pkg::*;

  localparam int unsigned Timeout     = 4;
  localparam int unsigned FlushCycles = 2;

  localparam int KOpImm  = 0;
  localparam int KLui    = 1;
  localparam int KOp     = 2;
  localparam int KJal    = 3;
  localparam int KJalr   = 4;
  localparam int KBr     = 5;
  localparam int KLoad   = 6;
  localparam int KStore  = 7;
  localparam int KIll    = 8;
  localparam int KMulDiv = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       b = 1'b0, mem_ack = 1'b0, md_done = 1'b0;
  logic [2:0] imm_type, cmp_op;
  logic       alu1_sel, alu2_sel;
  logic [3:0] alu_op;
  logic [1:0] rd_sel, pc_sel;
  logic       reg_wr, we, mem_req, md_start, stall, next_nop, err, illegal;

  always #5 clk = ~clk;

  ctrl_fsm #(
    .TIMEOUT      (Timeout),
    .FLUSH_CYCLES (FlushCycles)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .func3    (func3),
    .func7    (func7),
    .b        (b),
    .mem_ack  (mem_ack),
    .md_done  (md_done),
    .imm_type (imm_type),
    .alu1_sel (alu1_sel),
    .alu2_sel (alu2_sel),
    .alu_op   (alu_op),
    .cmp_op   (cmp_op),
    .rd_sel   (rd_sel),
    .pc_sel   (pc_sel),
    .reg_wr   (reg_wr),
    .we       (we),
    .mem_req  (mem_req),
    .md_start (md_start),
    .stall    (stall),
    .next_nop (next_nop),
    .err      (err),
    .illegal  (illegal)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          model_err = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // One cycle of stimulus plus the outputs it must produce.
  typedef struct {
    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       b, ack, done;
    logic       reg_wr, we, mem_req, md_start, stall, illegal, next_nop;
    logic [1:0] pc, rd;
    bit         chk_rd, chk_dec, chk_aop, chk_cmp, set_err;
    logic [2:0] imm, cmp;
    logic       a1, a2;
    logic [3:0] aop;
  } cyc_t;

  cyc_t q[$];

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    c.opc  = 5'($urandom);
    c.f3   = 3'($urandom);
    c.f7   = 7'($urandom);
    c.b    = 1'($urandom);
    c.ack  = 1'($urandom);
    c.done = 1'($urandom);
    c.pc   = PC_OLD;
    return c;
  endfunction

  // RISC-V ALU table: func3 selects the op, alt picks SUB/SRA.
  function automatic logic [3:0] ref_alu(logic [2:0] f3, logic alt);
    logic [3:0] tbl [8];
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (alt && f3 == 3'd0) return ALU_SUB;
    if (alt && f3 == 3'd5) return ALU_SRA;
    return tbl[f3];
  endfunction

  function automatic logic [2:0] ref_cmp(logic [2:0] f3);
    logic [2:0] tbl [8];
    tbl = '{CMP_EQ, CMP_NE, CMP_EQ, CMP_EQ, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU};
    return tbl[f3];
  endfunction

  task automatic apply(input cyc_t c);
    rst = 1'b1;
    opcode = c.opc; func3 = c.f3; func7 = c.f7;
    b = c.b; mem_ack = c.ack; md_done = c.done;
    #1;
    check_eq("reg_wr", 8'(reg_wr), 8'(c.reg_wr));
    check_eq("we", 8'(we), 8'(c.we));
    check_eq("mem_req", 8'(mem_req), 8'(c.mem_req));
    check_eq("md_start", 8'(md_start), 8'(c.md_start));
    check_eq("stall", 8'(stall), 8'(c.stall));
    check_eq("illegal", 8'(illegal), 8'(c.illegal));
    check_eq("next_nop", 8'(next_nop), 8'(c.next_nop));
    check_eq("pc_sel", 8'(pc_sel), 8'(c.pc));
    check_eq("err", 8'(err), 8'(model_err));
    if (c.chk_rd) check_eq("rd_sel", 8'(rd_sel), 8'(c.rd));
    if (c.chk_dec) begin
      check_eq("imm_type", 8'(imm_type), 8'(c.imm));
      check_eq("alu1_sel", 8'(alu1_sel), 8'(c.a1));
      check_eq("alu2_sel", 8'(alu2_sel), 8'(c.a2));
    end
    if (c.chk_aop) check_eq("alu_op", 8'(alu_op), 8'(c.aop));
    if (c.chk_cmp) check_eq("cmp_op", 8'(cmp_op), 8'(c.cmp));
    @(posedge clk);
    #1;
    if (c.set_err) model_err = 1'b1;
  endtask

  // Hold rst low for n cycles; outputs are forced quiet, then one RST_NOP cycle follows.
  task automatic do_reset(input int n, input logic [4:0] opc_after);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0;
      opcode = 5'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
      b = 1'($urandom); mem_ack = 1'($urandom); md_done = 1'($urandom);
      #1;
      check_eq("rst_reg_wr", 8'(reg_wr), 8'd0);
      check_eq("rst_we", 8'(we), 8'd0);
      check_eq("rst_mem_req", 8'(mem_req), 8'd0);
      check_eq("rst_md_start", 8'(md_start), 8'd0);
      check_eq("rst_stall", 8'(stall), 8'd0);
      check_eq("rst_illegal", 8'(illegal), 8'd0);
      check_eq("rst_pc_sel", 8'(pc_sel), 8'(PC_OLD));
      if (i > 0) begin
        check_eq("rst_next_nop", 8'(next_nop), 8'd1);
        check_eq("rst_err", 8'(err), 8'd0);
      end
      @(posedge clk);
      #1;
    end
    model_err = 1'b0;
    rst = 1'b1;
    opcode = opc_after; func3 = 3'($urandom); func7 = 7'($urandom);
    mem_ack = 1'($urandom); md_done = 1'($urandom);
    #1;
    check_eq("nop_next_nop", 8'(next_nop), 8'd1);
    check_eq("nop_pc_sel", 8'(pc_sel), 8'(PC_P4));
    check_eq("nop_reg_wr", 8'(reg_wr), 8'd0);
    check_eq("nop_mem_req", 8'(mem_req), 8'd0);
    check_eq("nop_stall", 8'(stall), 8'd0);
    check_eq("nop_err", 8'(err), 8'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_flush();
    cyc_t c;
    for (int i = 0; i < int'(FlushCycles); i++) begin
      c = blank();
      c.next_nop = 1'b1;
      c.pc = (i == 0) ? PC_P4 : PC_OLD;
      q.push_back(c);
    end
  endtask

  // lat: MEM cycle carrying mem_ack (> Timeout means never), or MD cycle carrying md_done.
  // abort_after: apply that many cycles, then reset (0 = run to completion).
  task automatic run_instr(input int kind, input int lat, input bit taken, input int abort_after);
    cyc_t c, w;
    logic [4:0] ill_tbl [5];
    int k;
    ill_tbl = '{5'b00101, 5'b00011, 5'b11100, 5'b01011, 5'b11111};
    c = blank();
    c.b = taken;
    if (kind == KOpImm || kind == KOp) c.f7 = $urandom_range(1) ? 7'b0100000 : 7'b0000000;
    c.chk_dec = 1'b1;
    c.imm = IMM_I; c.a1 = ALU1_RS; c.a2 = ALU2_IMM;
    c.pc = PC_P4;
    case (kind)
      KOpImm: begin
        c.opc = OPC_OP_IMM; c.reg_wr = 1'b1; c.rd = RD_ALU; c.chk_rd = 1'b1;
        c.aop = ref_alu(c.f3, c.f3 == 3'd5 && c.f7[5]); c.chk_aop = 1'b1;
        q.push_back(c);
      end
      KOp: begin
        c.opc = OPC_OP; c.reg_wr = 1'b1; c.rd = RD_ALU; c.chk_rd = 1'b1; c.a2 = ALU2_RS;
        c.aop = ref_alu(c.f3, c.f7[5]); c.chk_aop = 1'b1;
        q.push_back(c);
      end
      KLui: begin
        c.opc = OPC_LUI; c.imm = IMM_U; c.reg_wr = 1'b1; c.rd = RD_IMM; c.chk_rd = 1'b1;
        q.push_back(c);
      end
      KJal, KJalr: begin
        c.opc = (kind == KJal) ? OPC_JAL : OPC_JALR;
        if (kind == KJal) begin
          c.imm = IMM_J; c.a1 = ALU1_PC;
        end
        c.reg_wr = 1'b1; c.rd = RD_PCP4; c.chk_rd = 1'b1; c.pc = PC_ALU;
        q.push_back(c);
        push_flush();
      end
      KBr: begin
        c.opc = OPC_BRANCH; c.imm = IMM_B; c.a1 = ALU1_PC;
        c.cmp = ref_cmp(c.f3); c.chk_cmp = 1'b1;
        c.pc = taken ? PC_ALU : PC_P4;
        q.push_back(c);
        if (taken) push_flush();
      end
      KLoad, KStore: begin
        c.opc = (kind == KLoad) ? OPC_LOAD : OPC_STORE;
        if (kind == KStore) c.imm = IMM_S;
        c.mem_req = 1'b1; c.we = (kind == KStore); c.stall = 1'b1; c.pc = PC_OLD;
        q.push_back(c);
        for (int m = 1; m <= int'(Timeout); m++) begin
          w = c;
          w.chk_dec = 1'b0;
          w.ack = (m == lat);
          if (m == lat && kind == KLoad) begin
            q.push_back(w);
            w = blank();
            w.reg_wr = 1'b1; w.rd = RD_MEM; w.chk_rd = 1'b1; w.pc = PC_P4;
            q.push_back(w);
            push_flush();
            break;
          end else if (m == lat || m == int'(Timeout)) begin
            w.pc = PC_P4; w.stall = 1'b0; w.set_err = (m != lat);
            q.push_back(w);
            push_flush();
            break;
          end
          q.push_back(w);
        end
      end
      KMulDiv: begin
        c.opc = OPC_OP; c.f7 = 7'b0000001; c.a2 = ALU2_RS;
`ifdef CTRL_MULDIV_EN
        c.md_start = 1'b1; c.stall = 1'b1; c.pc = PC_OLD;
        q.push_back(c);
        for (int m = 1; m <= lat; m++) begin
          w = blank();
          w.opc = c.opc; w.f3 = c.f3; w.f7 = c.f7;
          w.done = (m == lat);
          if (m == lat) begin
            w.reg_wr = 1'b1; w.rd = RD_ALU; w.chk_rd = 1'b1; w.pc = PC_P4;
          end else begin
            w.stall = 1'b1;
          end
          q.push_back(w);
        end
`else
        c.illegal = 1'b1;
        q.push_back(c);
`endif
      end
      default: begin
        c.opc = ill_tbl[$urandom_range(4)]; c.illegal = 1'b1; c.chk_dec = 1'b0;
        q.push_back(c);
      end
    endcase
    k = 0;
    while (q.size() > 0) begin
      if (abort_after != 0 && k == abort_after) begin
        q.delete();
        do_reset(1, 5'($urandom));
        break;
      end
      apply(q.pop_front());
      k++;
    end
  endtask

  initial begin
    do_reset(2, OPC_OP_IMM);
    run_instr(KOpImm, 0, 1'b0, 0);
    run_instr(KBr, 0, 1'b1, 0);
    run_instr(KBr, 0, 1'b0, 0);
    run_instr(KLoad, 3, 1'b0, 0);
    run_instr(KStore, Timeout + 1, 1'b0, 0);
    run_instr(KLui, 0, 1'b0, 0);
    run_instr(KStore, 3, 1'b0, 2);
    run_instr(KLoad, Timeout, 1'b0, 0);
    run_instr(KMulDiv, 6, 1'b0, 0);
    run_instr(KIll, 0, 1'b0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0) do_reset($urandom_range(1, 2), 5'($urandom));
      run_instr($urandom_range(9), $urandom_range(1, Timeout + 1), 1'($urandom),
                ($urandom_range(19) == 0) ? $urandom_range(1, 3) : 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
